cpu_cycle_ctrl: RTL

CPU bus-cycle sequencer for the SDMAC register space. Consumes the decoded chip-select qualifiers from the address decoder and generates the 68030 cycle termination (DSACK_), a single-cycle internal register strobe, and the timed chip-select and read/write strobes for the WD33C93 register port. It also arbitrates the WD33C93 port between CPU register accesses and the DMA engine.

---
 rtl/cpu_cycle_ctrl_if.sv | 28 ++
 rtl/cpu_cycle_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/cpu_cycle_ctrl_if.sv
// CPU-side qualifiers, WD33C93 register-port strobes and DMA port handshake
// for the SDMAC bus-cycle sequencer.
interface cpu_cycle_ctrl_if;
   logic       AS_;
   logic       DMAC_;
   logic       RW;
   logic       INTREG;
   logic       WDREGREQ;
   logic       DMA_WD_REQ;
   logic [1:0] DSACK_;
   logic       REG_STB;
   logic       OE_;
   logic       LE_WD;
   logic       SCSI_CS_;
   logic       SCSI_RE_;
   logic       SCSI_WE_;
   logic       DMA_WD_GNT;

   modport master (
      output AS_, DMAC_, RW, INTREG, WDREGREQ, DMA_WD_REQ,
      input  DSACK_, REG_STB, OE_, LE_WD, SCSI_CS_, SCSI_RE_, SCSI_WE_, DMA_WD_GNT
   );

   modport slave (
      input  AS_, DMAC_, RW, INTREG, WDREGREQ, DMA_WD_REQ,
      output DSACK_, REG_STB, OE_, LE_WD, SCSI_CS_, SCSI_RE_, SCSI_WE_, DMA_WD_GNT
   );
endinterface

// File: rtl/cpu_cycle_ctrl.sv
// SDMAC CPU bus-cycle sequencer: DSACK_ termination, internal register strobe,
// timed WD33C93 register-port strobes and CPU/DMA arbitration of the WD port.
module cpu_cycle_ctrl #(
   parameter int unsigned WD_SETUP = 1,
   parameter int unsigned WD_PULSE = 3,
   parameter int unsigned WD_HOLD  = 1
) (
   input logic             CLK,
   input logic             RST_,
   cpu_cycle_ctrl_if.slave bus
);

   typedef enum logic [3:0] {
      S_IDLE, S_REG_ACC, S_REG_ACK, S_WD_WAIT, S_WD_SET,
      S_WD_STB, S_WD_HLD, S_WD_ACK, S_DMA_OWN, S_END
   } state_t;

   localparam logic [3:0] SETUP_LD = 4'(WD_SETUP - 1);
   localparam logic [3:0] PULSE_LD = 4'(WD_PULSE - 1);
   localparam logic [3:0] HOLD_LD  = 4'(WD_HOLD - 1);

   state_t     state, nxt;
   logic [3:0] cnt, cnt_nxt;
   logic       last_dma, last_dma_nxt;
   logic       wd_pend, wd_pend_nxt;
   logic       as_s1, as_s2, dmac_s1, dmac_s2;
   logic       sas;

   logic [1:0] dsack;
   logic       reg_stb, oe, le_wd, cs, re, we, gnt;

   always_ff @(posedge CLK or negedge RST_) begin
      if (!RST_) begin
         as_s1   <= 1'b1;
         as_s2   <= 1'b1;
         dmac_s1 <= 1'b1;
         dmac_s2 <= 1'b1;
      end else begin
         as_s1   <= bus.AS_;
         as_s2   <= as_s1;
         dmac_s1 <= bus.DMAC_;
         dmac_s2 <= dmac_s1;
      end
   end

   assign sas = ~as_s2 & ~dmac_s2;

   always_ff @(posedge CLK or negedge RST_) begin
      if (!RST_) begin
         state    <= S_IDLE;
         cnt      <= '0;
         last_dma <= 1'b1;
         wd_pend  <= 1'b0;
      end else begin
         state    <= nxt;
         cnt      <= cnt_nxt;
         last_dma <= last_dma_nxt;
         wd_pend  <= wd_pend_nxt;
      end
   end

   always_comb begin
      nxt          = state;
      cnt_nxt      = cnt;
      last_dma_nxt = last_dma;
      wd_pend_nxt  = wd_pend;
      case (state)
         S_IDLE: begin
            if (sas && bus.INTREG)
               nxt = S_REG_ACC;
            else if (sas && bus.WDREGREQ)
               nxt = (bus.DMA_WD_REQ && !last_dma) ? S_WD_WAIT : S_WD_SET;
            else if (bus.DMA_WD_REQ)
               nxt = S_DMA_OWN;
            else if (sas)
               nxt = S_END;
         end
         S_REG_ACC: nxt = sas ? S_REG_ACK : S_IDLE;
         S_REG_ACK: if (!sas) nxt = S_IDLE;
         S_WD_WAIT: if (!bus.DMA_WD_REQ) nxt = S_DMA_OWN;
         S_WD_SET:  if (cnt == '0) nxt = S_WD_STB;
         S_WD_STB:  if (cnt == '0) nxt = S_WD_HLD;
         // the WD timing always runs to completion; only the acknowledge is skipped on abort
         S_WD_HLD:  if (cnt == '0) nxt = sas ? S_WD_ACK : S_IDLE;
         S_WD_ACK:  if (!sas) nxt = S_IDLE;
         S_DMA_OWN: if (!bus.DMA_WD_REQ) nxt = (wd_pend && sas) ? S_WD_SET : S_IDLE;
         S_END:     if (!sas) nxt = S_IDLE;
         default:   nxt = S_IDLE;
      endcase

      if (nxt != state) begin
         case (nxt)
            S_WD_SET: begin
               cnt_nxt      = SETUP_LD;
               last_dma_nxt = 1'b0;
               wd_pend_nxt  = 1'b0;
            end
            S_WD_STB: cnt_nxt = PULSE_LD;
            S_WD_HLD: cnt_nxt = HOLD_LD;
            S_WD_WAIT: begin
               cnt_nxt      = '0;
               last_dma_nxt = 1'b1;
               wd_pend_nxt  = 1'b1;
            end
            S_DMA_OWN: begin
               cnt_nxt      = '0;
               last_dma_nxt = 1'b1;
            end
            S_IDLE: begin
               cnt_nxt     = '0;
               wd_pend_nxt = 1'b0;
            end
            default: cnt_nxt = '0;
         endcase
      end else if (cnt != '0) begin
         cnt_nxt = cnt - 4'd1;
      end
   end

   always_comb begin
      dsack   = 2'b11;
      reg_stb = 1'b0;
      oe      = 1'b1;
      le_wd   = 1'b0;
      cs      = 1'b1;
      re      = 1'b1;
      we      = 1'b1;
      gnt     = 1'b0;
      case (state)
         S_REG_ACC: begin
            reg_stb = 1'b1;
            oe      = ~bus.RW;
         end
         S_REG_ACK: begin
            dsack = 2'b00;
            oe    = ~bus.RW;
         end
         S_WD_SET: cs = 1'b0;
         S_WD_STB: begin
            cs    = 1'b0;
            re    = ~bus.RW;
            we    = bus.RW;
            le_wd = bus.RW && (cnt == '0);
         end
         S_WD_HLD: cs = 1'b0;
         S_WD_ACK: begin
            dsack = 2'b10;
            oe    = ~bus.RW;
         end
         S_WD_WAIT, S_DMA_OWN: gnt = bus.DMA_WD_REQ;
         default: ;
      endcase
   end

   assign bus.DSACK_     = dsack;
   assign bus.REG_STB    = reg_stb;
   assign bus.OE_        = oe;
   assign bus.LE_WD      = le_wd;
   assign bus.SCSI_CS_   = cs;
   assign bus.SCSI_RE_   = re;
   assign bus.SCSI_WE_   = we;
   assign bus.DMA_WD_GNT = gnt;

endmodule
